pc_fetch_sequencer: RTL and testbench

Multi-cycle instruction-fetch and PC sequencing controller for the LEGv8 core. Owns the architectural PC register, issues word fetches to instruction memory over a req/ack handshake, hands each fetched instruction to the datapath, and on the datapath's completion strobe applies branch resolution (PC+4, or PC + imm64×4 when taken). Sits between instruction memory and the decode/execute datapath, replacing the free-running PC update of the single-cycle build so that variable-latency memory can be used.

---
 rtl/pc_fetch_sequencer.sv | 150 +++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
// Multi-cycle fetch / PC sequencing controller for the LEGv8 core. Owns the
// architectural PC, fetches one instruction word at a time over a req/ack
// handshake, presents it to the datapath and applies branch resolution when
// the datapath signals completion. All outputs come straight from registers.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for run (or halt_req, which goes straight to HALT)
// FETCH  | imem_req high, waiting for imem_ack, timeout counter running
// EXEC   | instruction handed to datapath, waiting for exec_done
// HALT   | stopped cleanly at an instruction boundary; only Reset exits
// FAULT  | fetch timed out; only Reset exits

module pc_fetch_sequencer #(
  parameter int FETCH_TIMEOUT = 16,
  parameter int RETIRE_W      = 32
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic [63:0]         startPC,
  input  logic                run,
  input  logic                halt_req,
  output logic                imem_req,
  output logic [63:0]         imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_data,
  output logic [31:0]         instr,
  output logic                instr_valid,
  input  logic                exec_done,
  input  logic                unconditionalBranch,
  input  logic                conditionalBranch,
  input  logic                ALUzero,
  input  logic [63:0]         imm64,
  output logic [63:0]         currentPC,
  output logic [2:0]          state,
  output logic                fault,
  output logic [RETIRE_W-1:0] retired
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_EXEC  = 3'd2;
  localparam logic [2:0] ST_HALT  = 3'd3;
  localparam logic [2:0] ST_FAULT = 3'd4;

  // Last FETCH cycle count value before giving up; counter starts at 0 on
  // the first FETCH cycle, so FAULT lands exactly FETCH_TIMEOUT cycles in.
  localparam logic [7:0] TIMEOUT_LAST = 8'(FETCH_TIMEOUT - 1);

  localparam logic [RETIRE_W-1:0] RETIRE_ONE = {{(RETIRE_W-1){1'b0}}, 1'b1};

  logic [2:0]  state_next;
  logic [7:0]  fetch_cnt;
  logic        halt_pending;
  logic        halt_seen;
  logic        taken;
  logic [63:0] branch_offset;
  logic [63:0] pc_resolved;
  logic        retire_now;

  // Fetch address is the architectural PC, which only moves on retire.
  assign imem_addr = currentPC;

  // Branch resolution and next-PC selection (64-bit wraparound is intended).
  always_comb begin
    taken         = unconditionalBranch | (conditionalBranch & ALUzero);
    branch_offset = imm64 << 2;
    pc_resolved   = taken ? (currentPC + branch_offset) : (currentPC + 64'd4);
    halt_seen     = halt_pending | halt_req;
    retire_now    = (state == ST_EXEC) && exec_done;
  end

  // Next-state logic; ack wins over timeout in the same FETCH cycle.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (halt_req)
          state_next = ST_HALT;
        else if (run)
          state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack)
          state_next = ST_EXEC;
        else if (fetch_cnt >= TIMEOUT_LAST)
          state_next = ST_FAULT;
      end
      ST_EXEC: begin
        if (exec_done)
          state_next = halt_seen ? ST_HALT : ST_FETCH;
      end
      default: state_next = state;
    endcase
  end

  // State register and registered control outputs.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state       <= ST_IDLE;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_next;
      imem_req    <= (state_next == ST_FETCH);
      instr_valid <= (state == ST_FETCH) && imem_ack;
      fault       <= (state_next == ST_FAULT);
    end
  end

  // Fetch timeout counter: counts unacknowledged FETCH cycles.
  always_ff @(posedge CLK) begin
    if (Reset)
      fetch_cnt <= 8'd0;
    else if ((state == ST_FETCH) && !imem_ack)
      fetch_cnt <= fetch_cnt + 8'd1;
    else
      fetch_cnt <= 8'd0;
  end

  // Instruction latch: captured on the acknowledged fetch cycle.
  always_ff @(posedge CLK) begin
    if (Reset)
      instr <= 32'd0;
    else if ((state == ST_FETCH) && imem_ack)
      instr <= imem_data;
  end

  // Architectural PC and retire counter update only when an instruction completes.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      currentPC <= startPC;
      retired   <= '0;
    end else if (retire_now) begin
      currentPC <= pc_resolved;
      retired   <= retired + RETIRE_ONE;
    end
  end

  // Sticky halt request; the instruction in flight still finishes first.
  always_ff @(posedge CLK) begin
    if (Reset)
      halt_pending <= 1'b0;
    else if (halt_req && ((state == ST_IDLE) || (state == ST_FETCH) || (state == ST_EXEC)))
      halt_pending <= 1'b1;
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: inputs driven and outputs sampled on
// the falling edge, expected values hand-computed.

module tb_pc_fetch_sequencer;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [63:0] startPC;
  logic        run;
  logic        halt_req;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic        instr_valid;
  logic        exec_done;
  logic        unconditionalBranch;
  logic        conditionalBranch;
  logic        ALUzero;
  logic [63:0] imm64;
  logic [63:0] currentPC;
  logic [2:0]  state;
  logic        fault;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;

  pc_fetch_sequencer #(.FETCH_TIMEOUT(16), .RETIRE_W(32)) dut (
    .CLK(CLK), .Reset(Reset), .startPC(startPC), .run(run), .halt_req(halt_req),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_data(imem_data), .instr(instr), .instr_valid(instr_valid),
    .exec_done(exec_done), .unconditionalBranch(unconditionalBranch),
    .conditionalBranch(conditionalBranch), .ALUzero(ALUzero), .imm64(imm64),
    .currentPC(currentPC), .state(state), .fault(fault), .retired(retired)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, time=%0t required end before 200000", $time);
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    run = 0; halt_req = 0; imem_ack = 0; imem_data = 32'd0; exec_done = 0;
    unconditionalBranch = 0; conditionalBranch = 0; ALUzero = 0; imm64 = 64'd0;
  endtask

  // Reset for one edge with the given start PC, then release; ends in IDLE.
  task automatic do_reset(input logic [63:0] pc);
    idle_inputs();
    Reset = 1; startPC = pc;
    @(negedge CLK);
    Reset = 0;
  endtask

  // From IDLE: pulse run, end on the first FETCH cycle.
  task automatic start_run();
    run = 1;
    @(negedge CLK);
    run = 0;
  endtask

  // From a FETCH cycle: ack, check EXEC entry, retire with the given branch
  // inputs, and check the resolved PC and next fetch.
  task automatic fetch_exec(input string tag, input logic [31:0] data, input logic ub,
                            input logic cb, input logic z, input logic [63:0] imm,
                            input logic [63:0] exp_pc, input logic [31:0] exp_ret);
    imem_ack = 1; imem_data = data;
    @(negedge CLK);
    imem_ack = 0;
    check_val({tag, ".exec_state"}, 64'(state), 64'd2);
    check_val({tag, ".instr"}, 64'(instr), 64'(data));
    check_val({tag, ".instr_valid"}, 64'(instr_valid), 64'd1);
    exec_done = 1; unconditionalBranch = ub; conditionalBranch = cb; ALUzero = z; imm64 = imm;
    @(negedge CLK);
    exec_done = 0; unconditionalBranch = 0; conditionalBranch = 0; ALUzero = 0;
    check_val({tag, ".pc"}, currentPC, exp_pc);
    check_val({tag, ".addr"}, imem_addr, exp_pc);
    check_val({tag, ".retired"}, 64'(retired), 64'(exp_ret));
    check_val({tag, ".refetch"}, 64'(imem_req), 64'd1);
  endtask

  initial begin
    Reset = 1;
    startPC = 64'd0;
    idle_inputs();

    // Reset state and unconditional branch with a 2-cycle ack latency.
    do_reset(64'h1000);
    check_val("rst.state", 64'(state), 64'd0);
    check_val("rst.pc", currentPC, 64'h1000);
    check_val("rst.req", 64'(imem_req), 64'd0);
    check_val("rst.retired", 64'(retired), 64'd0);
    check_val("rst.fault", 64'(fault), 64'd0);
    check_val("rst.instr", 64'(instr), 64'd0);
    @(negedge CLK);
    check_val("idle.hold", 64'(state), 64'd0);
    start_run();
    check_val("run.state", 64'(state), 64'd1);
    check_val("run.req", 64'(imem_req), 64'd1);
    check_val("run.addr", imem_addr, 64'h1000);
    @(negedge CLK);
    check_val("wait.addr", imem_addr, 64'h1000);
    fetch_exec("ub", 32'hDEADBEEF, 1, 0, 0, 64'd4, 64'h1010, 1);
    // Second instruction: exec_done held off a cycle; instr_valid must drop.
    imem_ack = 1; imem_data = 32'h8B020020;
    @(negedge CLK);
    imem_ack = 0;
    check_val("slow.req_low", 64'(imem_req), 64'd0);
    @(negedge CLK);
    check_val("slow.still_exec", 64'(state), 64'd2);
    check_val("slow.valid_pulse", 64'(instr_valid), 64'd0);
    exec_done = 1; conditionalBranch = 0; ALUzero = 1; imm64 = 64'h40;
    @(negedge CLK);
    exec_done = 0; ALUzero = 0;
    check_val("slow.pc", currentPC, 64'h1014);
    check_val("slow.retired", 64'(retired), 64'd2);

    // Conditional branch taken / not taken.
    do_reset(64'h2000);
    start_run();
    fetch_exec("cbz_t", 32'hB4000080, 0, 1, 1, 64'd4, 64'h2010, 1);
    do_reset(64'h2000);
    start_run();
    fetch_exec("cbz_n", 32'hB4000080, 0, 1, 0, 64'd4, 64'h2004, 1);

    // Backward branch and PC wraparound.
    do_reset(64'h5000);
    start_run();
    fetch_exec("back", 32'h17FFFFFC, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h4FF0, 1);
    do_reset(64'hFFFF_FFFF_FFFF_FFFC);
    start_run();
    fetch_exec("wrap", 32'h00000000, 0, 0, 1, 64'h10, 64'h0, 1);

    // Fetch timeout: FAULT exactly 16 cycles after FETCH entry.
    do_reset(64'h7000);
    start_run();
    for (int i = 1; i < 16; i++) @(negedge CLK);
    check_val("to.cycle16", 64'(state), 64'd1);
    @(negedge CLK);
    check_val("to.state", 64'(state), 64'd4);
    check_val("to.fault", 64'(fault), 64'd1);
    check_val("to.req", 64'(imem_req), 64'd0);
    exec_done = 1; unconditionalBranch = 1; imem_ack = 1;
    @(negedge CLK);
    idle_inputs();
    check_val("to.frozen_state", 64'(state), 64'd4);
    check_val("to.frozen_pc", currentPC, 64'h7000);

    // Ack on the 16th cycle wins over the timeout.
    do_reset(64'h7000);
    start_run();
    for (int i = 1; i < 16; i++) @(negedge CLK);
    imem_ack = 1; imem_data = 32'h12345678;
    @(negedge CLK);
    imem_ack = 0;
    check_val("late.state", 64'(state), 64'd2);
    check_val("late.fault", 64'(fault), 64'd0);

    // halt_req mid-FETCH: in-flight instruction retires, then HALT.
    do_reset(64'h6000);
    start_run();
    halt_req = 1;
    @(negedge CLK);
    halt_req = 0;
    check_val("halt.fetching", 64'(state), 64'd1);
    imem_ack = 1; imem_data = 32'hAAAA5555;
    @(negedge CLK);
    imem_ack = 0;
    check_val("halt.exec", 64'(state), 64'd2);
    exec_done = 1;
    @(negedge CLK);
    exec_done = 0;
    check_val("halt.state", 64'(state), 64'd3);
    check_val("halt.pc", currentPC, 64'h6004);
    check_val("halt.retired", 64'(retired), 64'd1);
    check_val("halt.req", 64'(imem_req), 64'd0);
    run = 1;
    @(negedge CLK);
    run = 0;
    check_val("halt.stays", 64'(state), 64'd3);

    // halt_req in IDLE goes straight to HALT.
    do_reset(64'h0);
    halt_req = 1; run = 1;
    @(negedge CLK);
    halt_req = 0; run = 0;
    check_val("idle_halt.state", 64'(state), 64'd3);
    check_val("idle_halt.req", 64'(imem_req), 64'd0);

    // Reset mid-EXEC discards exec_done and reloads the PC.
    do_reset(64'h1000);
    start_run();
    fetch_exec("pre_rst", 32'h11111111, 0, 0, 0, 64'd0, 64'h1004, 1);
    imem_ack = 1;
    @(negedge CLK);
    imem_ack = 0;
    check_val("mid.exec", 64'(state), 64'd2);
    Reset = 1; startPC = 64'h3000; exec_done = 1; unconditionalBranch = 1; imm64 = 64'd8;
    @(negedge CLK);
    Reset = 0; exec_done = 0; unconditionalBranch = 0;
    check_val("mid.state", 64'(state), 64'd0);
    check_val("mid.pc", currentPC, 64'h3000);
    check_val("mid.retired", 64'(retired), 64'd0);
    check_val("mid.valid", 64'(instr_valid), 64'd0);
    check_val("mid.req", 64'(imem_req), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
